// File: rtl/mem_access.sv
// Memory-access stage: NOP/misaligned ops retire next edge; loads write back 1 cycle after ack.
// stallreq_o holds upstream from an aligned access until the ack (or timeout) cycle.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_WIDTH       = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_op_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [3:0] MEM_NOP = 4'd0, MEM_LB = 4'd1, MEM_LH = 4'd2, MEM_LW = 4'd3,
                         MEM_LBU = 4'd4, MEM_LHU = 4'd5, MEM_SB = 4'd6, MEM_SH = 4'd7,
                         MEM_SW = 4'd8;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t              state_q, state_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]          be_q, be_d, op_q, op_d;
  logic [4:0]          waddr_q, waddr_d;
  logic                reg_we_q, reg_we_d, we_q, we_d, is_load_q, is_load_d;
  logic                wb_we_q, wb_we_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [4:0]          wb_waddr_q, wb_waddr_d;
  logic [31:0]         wb_wdata_q, wb_wdata_d;

  logic        is_load, is_store, is_byte, is_half, misaligned, timeout_hit;
  logic [1:0]  off;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    off        = mem_addr_i[1:0];
    is_load    = (mem_op_i == MEM_LB) || (mem_op_i == MEM_LH) || (mem_op_i == MEM_LW) ||
                 (mem_op_i == MEM_LBU) || (mem_op_i == MEM_LHU);
    is_store   = (mem_op_i == MEM_SB) || (mem_op_i == MEM_SH) || (mem_op_i == MEM_SW);
    is_byte    = (mem_op_i == MEM_LB) || (mem_op_i == MEM_LBU) || (mem_op_i == MEM_SB);
    is_half    = (mem_op_i == MEM_LH) || (mem_op_i == MEM_LHU) || (mem_op_i == MEM_SH);
    misaligned = is_half ? off[0] : (!is_byte && (off != 2'b00));
    if (is_byte) begin
      be_in    = 4'b0001 << off;
      wdata_in = {4{mem_data_i[7:0]}};
    end else if (is_half) begin
      be_in    = off[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{mem_data_i[15:0]}};
    end else begin
      be_in    = 4'b1111;
      wdata_in = mem_data_i;
    end
  end

  // Lane selection is driven by the latched offset so rdata aligns to the op in flight.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = dbus_rdata_i[7:0];
      2'd1:    lane_b = dbus_rdata_i[15:8];
      2'd2:    lane_b = dbus_rdata_i[23:16];
      default: lane_b = dbus_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (op_q)
      MEM_LB:  load_data = {{24{lane_b[7]}}, lane_b};
      MEM_LBU: load_data = {24'd0, lane_b};
      MEM_LH:  load_data = {{16{lane_h[15]}}, lane_h};
      MEM_LHU: load_data = {16'd0, lane_h};
      default: load_data = dbus_rdata_i;
    endcase
  end

  assign timeout_hit = TO_EN && (cnt_q == TO_LAST) && !dbus_ack_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    op_d       = op_q;
    waddr_d    = waddr_q;
    reg_we_d   = reg_we_q;
    we_d       = we_q;
    is_load_d  = is_load_q;
    wb_we_d    = wb_we_q;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stallreq_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!(is_load || is_store)) begin
          wb_we_d    = reg_we_i;
          wb_waddr_d = reg_waddr_i;
          wb_wdata_d = reg_wdata_i;
        end else if (misaligned) begin
          misalign_d = 1'b1;
          wb_we_d    = 1'b0;
        end else begin
          stallreq_o = 1'b1;
          state_d    = S_BUS;
          cnt_d      = '0;
          addr_d     = mem_addr_i;
          wdata_d    = wdata_in;
          be_d       = be_in;
          op_d       = mem_op_i;
          waddr_d    = reg_waddr_i;
          reg_we_d   = reg_we_i;
          we_d       = mem_we_i;
          is_load_d  = is_load;
          wb_we_d    = 1'b0;
        end
      end
      default: begin
        stallreq_o = !dbus_ack_i && !timeout_hit;
        wb_we_d    = 1'b0;
        if (dbus_ack_i) begin
          state_d = S_IDLE;
          if (is_load_q) begin
            wb_we_d    = reg_we_q;
            wb_waddr_d = waddr_q;
            wb_wdata_d = load_data;
          end
        end else if (timeout_hit) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      op_q       <= MEM_NOP;
      waddr_q    <= '0;
      reg_we_q   <= 1'b0;
      we_q       <= 1'b0;
      is_load_q  <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= '0;
      wb_wdata_q <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      op_q       <= op_d;
      waddr_q    <= waddr_d;
      reg_we_q   <= reg_we_d;
      we_q       <= we_d;
      is_load_q  <= is_load_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Bus signals come straight from state/latched regs so reset drops req without an edge.
  assign dbus_req_o   = (state_q == S_BUS);
  assign dbus_we_o    = (state_q == S_BUS) && we_q;
  assign dbus_addr_o  = {addr_q[31:2], 2'b00};
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign wb_we_o      = wb_we_q;
  assign wb_waddr_o   = wb_waddr_q;
  assign wb_wdata_o   = wb_wdata_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a short bus timeout.
module tb_mem_access;

  localparam logic [3:0] NOP = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LHU = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        reg_we_i = 1'b0, mem_we_i = 1'b0, dbus_ack_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] reg_wdata_i = '0, mem_addr_i = '0, mem_data_i = '0, dbus_rdata_i = '0;
  logic [3:0]  mem_op_i = NOP;
  logic        dbus_req_o, dbus_we_o, wb_we_o, stallreq_o, misalign_o, bus_err_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, wb_wdata_o;
  logic [3:0]  dbus_be_o;
  logic [4:0]  wb_waddr_o;

  int tests = 0;
  int fails = 0;

  mem_access #(.TIMEOUT_CYCLES(4), .TO_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_we_i(mem_we_i),
    .mem_op_i(mem_op_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o),
    .stallreq_o(stallreq_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic rwe, input logic [4:0] waddr, input logic [31:0] wdata);
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_data_i  = data;
    mem_we_i    = (op == SB) || (op == SH) || (op == SW);
    reg_we_i    = rwe;
    reg_waddr_i = waddr;
    reg_wdata_i = wdata;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_wdata", wb_wdata_o, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);
    tick();
    rst_i = 1'b0;

    // ALU result passes straight through
    drive(NOP, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
    #1 chk("nop_stall", {31'd0, stallreq_o}, 32'd0);
    tick();
    chk("nop_wb", {26'd0, wb_we_o, wb_waddr_o}, {26'd0, 1'b1, 5'd5});
    chk("nop_wdata", wb_wdata_o, 32'h1234);

    // LB at offset 3, ack on first bus cycle
    drive(LB, 32'h1003, 32'h0, 1'b1, 5'd7, 32'h0);
    #1 chk("lb_stall0", {31'd0, stallreq_o}, 32'd1);
    chk("lb_req0", {31'd0, dbus_req_o}, 32'd0);
    tick();
    chk("lb_req1", {31'd0, dbus_req_o}, 32'd1);
    chk("lb_addr", dbus_addr_o, 32'h1000);
    chk("lb_be", {28'd0, dbus_be_o}, 32'h8);
    chk("lb_we", {31'd0, dbus_we_o}, 32'd0);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h80FF_FF11;
    #1 chk("lb_stall_ack", {31'd0, stallreq_o}, 32'd0);
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    dbus_ack_i = 1'b0;
    chk("lb_wb", {26'd0, wb_we_o, wb_waddr_o}, {26'd0, 1'b1, 5'd7});
    chk("lb_wdata", wb_wdata_o, 32'hFFFF_FF80);
    chk("lb_req_drop", {31'd0, dbus_req_o}, 32'd0);

    // LHU at offset 2 zero-extends upper half
    drive(LHU, 32'h1102, 32'h0, 1'b1, 5'd8, 32'h0);
    tick();
    chk("lhu_be", {28'd0, dbus_be_o}, 32'hC);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h8001_7FFF;
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    dbus_ack_i = 1'b0;
    chk("lhu_wdata", wb_wdata_o, 32'h0000_8001);

    // LH at offset 0 sign-extends lower half
    drive(LH, 32'h1200, 32'h0, 1'b1, 5'd9, 32'h0);
    tick();
    chk("lh_be", {28'd0, dbus_be_o}, 32'h3);
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1234_F00D;
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    dbus_ack_i = 1'b0;
    chk("lh_wdata", wb_wdata_o, 32'hFFFF_F00D);

    // SH at offset 2, ack after three wait cycles (lands on the timeout cycle: ack wins)
    drive(SH, 32'h2002, 32'hAAAA_BEEF, 1'b1, 5'd3, 32'h0);
    #1 chk("sh_stall0", {31'd0, stallreq_o}, 32'd1);
    tick();
    chk("sh_be", {28'd0, dbus_be_o}, 32'hC);
    chk("sh_wdata", dbus_wdata_o, 32'hBEEF_BEEF);
    chk("sh_addr", dbus_addr_o, 32'h2000);
    chk("sh_we", {31'd0, dbus_we_o}, 32'd1);
    chk("sh_stall1", {31'd0, stallreq_o}, 32'd1);
    tick();
    chk("sh_stall2", {31'd0, stallreq_o}, 32'd1);
    tick();
    chk("sh_stall3", {31'd0, stallreq_o}, 32'd1);
    tick();
    dbus_ack_i = 1'b1;
    #1 chk("sh_stall4", {31'd0, stallreq_o}, 32'd0);
    chk("sh_req4", {31'd0, dbus_req_o}, 32'd1);
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    dbus_ack_i = 1'b0;
    chk("sh_wb_we", {31'd0, wb_we_o}, 32'd0);
    chk("sh_no_err", {31'd0, bus_err_o}, 32'd0);
    chk("sh_req_drop", {31'd0, dbus_req_o}, 32'd0);

    // Misaligned LW is dropped without a bus access
    drive(LW, 32'h3001, 32'h0, 1'b1, 5'd4, 32'h0);
    #1 chk("mis_stall", {31'd0, stallreq_o}, 32'd0);
    tick();
    chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
    chk("mis_wb_we", {31'd0, wb_we_o}, 32'd0);
    chk("mis_req", {31'd0, dbus_req_o}, 32'd0);
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("mis_pulse_end", {31'd0, misalign_o}, 32'd0);

    // LW that never gets an ack times out after four bus cycles
    drive(LW, 32'h4000, 32'h0, 1'b1, 5'd6, 32'h0);
    dbus_rdata_i = 32'hDEAD_BEEF;
    tick();
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("to_req%0d", c), {31'd0, dbus_req_o}, 32'd1);
      chk($sformatf("to_stall%0d", c), {31'd0, stallreq_o}, 32'd1);
      tick();
    end
    chk("to_req4", {31'd0, dbus_req_o}, 32'd1);
    chk("to_stall4", {31'd0, stallreq_o}, 32'd0);
    drive(NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("to_req_drop", {31'd0, dbus_req_o}, 32'd0);
    chk("to_bus_err", {31'd0, bus_err_o}, 32'd1);
    chk("to_wb_we", {31'd0, wb_we_o}, 32'd0);
    tick();
    chk("to_err_end", {31'd0, bus_err_o}, 32'd0);

    // Reset in the middle of a bus access
    drive(LW, 32'h5000, 32'h0, 1'b1, 5'd2, 32'h0);
    tick();
    chk("rb_req", {31'd0, dbus_req_o}, 32'd1);
    #2 rst_i = 1'b1;
    drive(NOP, 32'h0, 32'h0, 1'b1, 5'd9, 32'hCAFE);
    #1 chk("rb_req_async", {31'd0, dbus_req_o}, 32'd0);
    chk("rb_outs", {29'd0, wb_we_o, misalign_o, bus_err_o}, 32'd0);
    chk("rb_stall", {31'd0, stallreq_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("rb_nop_wb", {26'd0, wb_we_o, wb_waddr_o}, {26'd0, 1'b1, 5'd9});
    chk("rb_nop_wdata", wb_wdata_o, 32'hCAFE);
    chk("rb_no_err", {31'd0, bus_err_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
